bonus_scheduler: RTL and testbench

- Central sequencer for in-game bonuses, clocked on clk_run.
- Decides when a supply item drops and which one (bomb or double-shoot bullet), and issues one-cycle spawn pulses with a randomized x position to the supply sprite blocks.
- Owns the player's bomb inventory and the double-shoot timeout. Feeds shoot_mode to the bullet generator and a screen-clear pulse to the enemy logic.

---
 rtl/bonus_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_bonus_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bonus_scheduler.sv
// Bonus scheduler: decides when a supply item drops and which one, issues
// one-cycle spawn pulses with a clipped random x position, and owns the
// player's bomb inventory and the double-shoot timeout.
module bonus_scheduler #(
    parameter int RAND_W        = 10,
    parameter int X_W           = 10,
    parameter int X_MAX         = 440,
    parameter int MIN_INTERVAL  = 200,
    parameter int INTERVAL_MASK = 255,
    parameter int DOUBLE_TICKS  = 1000,
    parameter int MAX_BOMBS     = 3,
    parameter int CNT_W         = 16
) (
    input  logic              clk_run,
    input  logic              rst,
    input  logic              en_i,
    input  logic [RAND_W-1:0] rand_i,
    input  logic              bomb_active_i,
    input  logic              bullet_active_i,
    input  logic              bomb_taken_i,
    input  logic              bullet_taken_i,
    input  logic              bomb_use_i,
    output logic              spawn_bomb_o,
    output logic              spawn_bullet_o,
    output logic [X_W-1:0]    spawn_x_o,
    output logic [1:0]        bomb_cnt_o,
    output logic              clear_screen_o,
    output logic              shoot_mode_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COOLDOWN,
        ST_PICK,
        ST_SPAWN
    } state_t;

    // Spawn sequencer state
    state_t           state_q;
    logic [CNT_W-1:0] cooldown_q;
    logic             spawn_bomb_q;
    logic             spawn_bullet_q;
    logic [X_W-1:0]   spawn_x_q;

    // Double-shoot timeout
    logic [CNT_W-1:0] double_q;
    logic             shoot_mode_q;

    // Bomb inventory
    logic [1:0]       bomb_cnt_q;
    logic [1:0]       bomb_cnt_d;
    logic             clear_q;

    // Combinational helpers
    logic [CNT_W-1:0] reload_val;
    logic [X_W-1:0]   clip_x;
    logic             prefer_bomb;
    logic             pref_busy;
    logic             other_busy;
    logic             both_busy;
    logic             pick_bomb;
    logic             bomb_use_ok;
    logic [2:0]       bomb_sum;

    // Next cooldown length: fixed floor plus a masked random spread
    assign reload_val = CNT_W'(MIN_INTERVAL)
                      + CNT_W'(rand_i & RAND_W'(INTERVAL_MASK));

    // Random x position clipped to the right edge of the legal spawn band
    assign clip_x = (rand_i[X_W-1:0] > X_W'(X_MAX)) ? X_W'(X_MAX)
                                                    : rand_i[X_W-1:0];

    // Item choice: random preference, redirected to the free item when the
    // preferred one is already on screen; both busy means wait in PICK
    always_comb begin
        prefer_bomb = rand_i[0];
        pref_busy   = prefer_bomb ? bomb_active_i   : bullet_active_i;
        other_busy  = prefer_bomb ? bullet_active_i : bomb_active_i;
        both_busy   = bomb_active_i && bullet_active_i;
        pick_bomb   = (pref_busy && !other_busy) ? !prefer_bomb : prefer_bomb;
    end

    // Spawn sequencer: cooldown, item pick, one-cycle spawn pulse; pausing
    // the game drops the pending cooldown and any spawn in progress
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cooldown_q     <= '0;
            spawn_bomb_q   <= 1'b0;
            spawn_bullet_q <= 1'b0;
            spawn_x_q      <= '0;
        end else begin
            spawn_bomb_q   <= 1'b0;
            spawn_bullet_q <= 1'b0;
            if (!en_i) begin
                state_q    <= ST_IDLE;
                cooldown_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cooldown_q <= reload_val;
                        state_q    <= ST_COOLDOWN;
                    end
                    ST_COOLDOWN: begin
                        if (cooldown_q == '0) begin
                            state_q <= ST_PICK;
                        end else begin
                            cooldown_q <= cooldown_q - CNT_W'(1);
                        end
                    end
                    ST_PICK: begin
                        // The pulse register is loaded here so it is high
                        // for exactly the cycle spent in SPAWN
                        if (!both_busy) begin
                            spawn_bomb_q   <= pick_bomb;
                            spawn_bullet_q <= !pick_bomb;
                            spawn_x_q      <= clip_x;
                            state_q        <= ST_SPAWN;
                        end
                    end
                    ST_SPAWN: begin
                        cooldown_q <= reload_val;
                        state_q    <= ST_COOLDOWN;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Double-shoot timeout: a pickup reloads the full period, the count
    // freezes while paused, and the mode drops on the 1->0 step
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            double_q     <= '0;
            shoot_mode_q <= 1'b0;
        end else if (bullet_taken_i) begin
            double_q     <= CNT_W'(DOUBLE_TICKS);
            shoot_mode_q <= 1'b1;
        end else if (en_i && (double_q != '0)) begin
            double_q <= double_q - CNT_W'(1);
            if (double_q == CNT_W'(1)) begin
                shoot_mode_q <= 1'b0;
            end
        end
    end

    // Bomb inventory arithmetic on the pre-update count; a use with an
    // empty inventory is dropped, and the total saturates at the cap
    always_comb begin
        bomb_use_ok = bomb_use_i && (bomb_cnt_q != 2'd0);
        bomb_sum    = {1'b0, bomb_cnt_q} - {2'b00, bomb_use_ok}
                    + {2'b00, bomb_taken_i};
        if (bomb_sum > 3'(MAX_BOMBS)) begin
            bomb_cnt_d = 2'(MAX_BOMBS);
        end else begin
            bomb_cnt_d = bomb_sum[1:0];
        end
    end

    // Bomb inventory register and the registered screen-clear pulse
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            bomb_cnt_q <= 2'd0;
            clear_q    <= 1'b0;
        end else begin
            bomb_cnt_q <= bomb_cnt_d;
            clear_q    <= bomb_use_ok;
        end
    end

    assign spawn_bomb_o   = spawn_bomb_q;
    assign spawn_bullet_o = spawn_bullet_q;
    assign spawn_x_o      = spawn_x_q;
    assign bomb_cnt_o     = bomb_cnt_q;
    assign clear_screen_o = clear_q;
    assign shoot_mode_o   = shoot_mode_q;

endmodule

// File: tb/tb_bonus_scheduler.sv
// Self-checking bench for bonus_scheduler: directed scenarios with literal
// expectations plus a randomized run, all shadowed by a behavioural model.
module tb_bonus_scheduler;

    localparam int MIN_I  = 4;
    localparam int MASK_I = 7;
    localparam int DBL    = 10;
    localparam int XMAX   = 440;
    localparam int MAXB   = 3;

    logic       clk_run = 1'b0;
    logic       rst     = 1'b1;
    logic       en_i    = 1'b0;
    logic [9:0] rand_i  = '0;
    logic       bomb_active_i   = 1'b0;
    logic       bullet_active_i = 1'b0;
    logic       bomb_taken_i    = 1'b0;
    logic       bullet_taken_i  = 1'b0;
    logic       bomb_use_i      = 1'b0;
    logic       spawn_bomb_o;
    logic       spawn_bullet_o;
    logic [9:0] spawn_x_o;
    logic [1:0] bomb_cnt_o;
    logic       clear_screen_o;
    logic       shoot_mode_o;

    int errors = 0;
    int checks = 0;
    bit run_checks = 0;

    bonus_scheduler #(
        .RAND_W(10), .X_W(10), .X_MAX(XMAX), .MIN_INTERVAL(MIN_I),
        .INTERVAL_MASK(MASK_I), .DOUBLE_TICKS(DBL), .MAX_BOMBS(MAXB), .CNT_W(16)
    ) dut (
        .clk_run(clk_run), .rst(rst), .en_i(en_i), .rand_i(rand_i),
        .bomb_active_i(bomb_active_i), .bullet_active_i(bullet_active_i),
        .bomb_taken_i(bomb_taken_i), .bullet_taken_i(bullet_taken_i),
        .bomb_use_i(bomb_use_i), .spawn_bomb_o(spawn_bomb_o),
        .spawn_bullet_o(spawn_bullet_o), .spawn_x_o(spawn_x_o),
        .bomb_cnt_o(bomb_cnt_o), .clear_screen_o(clear_screen_o),
        .shoot_mode_o(shoot_mode_o)
    );

    always #5 clk_run = ~clk_run;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_wait: edges left until the next pick attempt (-1 = not armed);
    // m_spawned: a pulse is out, next edge re-arms from rand_i.
    int m_wait;
    bit m_spawned;
    int m_dbl;
    int m_bombs;
    bit e_sb, e_su, e_clr, e_mode;
    int e_x;
    int r_m, n_m;
    bit pb_m, use_m;

    always @(posedge clk_run or posedge rst) begin
        if (rst) begin
            m_wait = -1; m_spawned = 0; m_dbl = 0; m_bombs = 0;
            e_sb = 0; e_su = 0; e_clr = 0; e_mode = 0; e_x = 0;
        end else begin
            r_m  = int'(rand_i);
            e_sb = 0;
            e_su = 0;
            if (!en_i) begin
                m_wait = -1;
                m_spawned = 0;
            end else if (m_wait < 0 || m_spawned) begin
                // cooldown of N ticks, one tick to notice zero, one to pick
                m_wait = MIN_I + (r_m & MASK_I) + 2;
                m_spawned = 0;
            end else begin
                if (m_wait > 0) m_wait--;
                if (m_wait == 0 && !(bomb_active_i && bullet_active_i)) begin
                    pb_m = (r_m % 2) == 1;
                    if (pb_m ? bomb_active_i : bullet_active_i) pb_m = !pb_m;
                    e_sb = pb_m;
                    e_su = !pb_m;
                    e_x  = ((r_m % 1024) > XMAX) ? XMAX : (r_m % 1024);
                    m_spawned = 1;
                end
            end
            if (bullet_taken_i) m_dbl = DBL;
            else if (en_i && m_dbl > 0) m_dbl--;
            e_mode = m_dbl > 0;
            use_m = bomb_use_i && m_bombs > 0;
            n_m = m_bombs - int'(use_m) + int'(bomb_taken_i);
            m_bombs = (n_m > MAXB) ? MAXB : n_m;
            e_clr = use_m;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk_run) begin
        if (run_checks && !rst) begin
            chk("spawn_bomb", int'(spawn_bomb_o), int'(e_sb));
            chk("spawn_bullet", int'(spawn_bullet_o), int'(e_su));
            if (e_sb || e_su) chk("spawn_x", int'(spawn_x_o), e_x);
            chk("spawn_exclusive", int'(spawn_bomb_o & spawn_bullet_o), 0);
            chk("bomb_cnt", int'(bomb_cnt_o), m_bombs);
            chk("clear_screen", int'(clear_screen_o), int'(e_clr));
            chk("shoot_mode", int'(shoot_mode_o), int'(e_mode));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic measure_spawn(input int window, output int first_idx, output int npulses,
                                 output int kind, output int xval, output int side_nz);
        first_idx = -1; npulses = 0; kind = 0; xval = 0; side_nz = 0;
        for (int idx = 0; idx < window; idx++) begin
            @(posedge clk_run); #1;
            if (spawn_bomb_o || spawn_bullet_o) begin
                npulses++;
                if (first_idx < 0) begin
                    first_idx = idx;
                    kind = spawn_bomb_o ? 1 : 2;
                    xval = int'(spawn_x_o);
                end
            end
            if (shoot_mode_o || bomb_cnt_o != 2'd0) side_nz = 1;
        end
    endtask

    task automatic wait_spawn(input int limit, output int idx, output int kind, output int xval);
        idx = -1; kind = 0; xval = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_run); #1;
            if (spawn_bomb_o || spawn_bullet_o) begin
                idx = i;
                kind = spawn_bomb_o ? 1 : 2;
                xval = int'(spawn_x_o);
                break;
            end
        end
    endtask

    task automatic bomb_op(input bit take, input bit use_b, output int cnt, output int clr);
        bomb_taken_i = take;
        bomb_use_i   = use_b;
        @(posedge clk_run); #1;
        bomb_taken_i = 0;
        bomb_use_i   = 0;
        cnt = int'(bomb_cnt_o);
        clr = int'(clear_screen_o);
    endtask

    task automatic run_double(input int second_at, input int pause_at, output int highs);
        int pc;
        bit paused;
        highs = 0; pc = 0; paused = 0;
        bullet_taken_i = 1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_run); #1;
            bullet_taken_i = 0;
            if (shoot_mode_o) highs++;
            else break;
            if (paused) begin
                pc++;
                if (pc == 3) begin en_i = 1; paused = 0; end
            end else if (pause_at > 0 && highs == pause_at) begin
                en_i = 0; paused = 1;
            end
            if (second_at > 0 && highs == second_at) bullet_taken_i = 1;
        end
        en_i = 1;
        bullet_taken_i = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fi, np, kd, xv, sn, cnt, clr, hi;
        int exp_take[4];
        exp_take = '{1, 2, 3, 3};

        // Reset state
        repeat (3) @(posedge clk_run);
        #1;
        chk("rst_spawn_bomb", int'(spawn_bomb_o), 0);
        chk("rst_spawn_bullet", int'(spawn_bullet_o), 0);
        chk("rst_bomb_cnt", int'(bomb_cnt_o), 0);
        chk("rst_clear", int'(clear_screen_o), 0);
        chk("rst_shoot_mode", int'(shoot_mode_o), 0);
        chk("rst_spawn_x", int'(spawn_x_o), 0);

        // First spawn: rand 0, nothing on screen -> bullet at edge 6
        rst = 0; en_i = 1; rand_i = 10'd0; run_checks = 1;
        measure_spawn(13, fi, np, kd, xv, sn);
        chk("first_spawn_latency", fi, 6);
        chk("first_spawn_count", np, 1);
        chk("first_spawn_kind_bullet", kd, 2);
        chk("first_spawn_x", xv, 0);
        chk("first_spawn_side_quiet", sn, 0);

        // Bomb preferred but on screen -> bullet, x clipped to 440
        rand_i = 10'd1001; bomb_active_i = 1; bullet_active_i = 0;
        wait_spawn(25, fi, kd, xv);
        chk("redirect_seen", int'(fi >= 0), 1);
        chk("redirect_kind_bullet", kd, 2);
        chk("clip_x", xv, XMAX);

        // Both on screen -> stalled until bullet clears
        bullet_active_i = 1;
        measure_spawn(25, fi, np, kd, xv, sn);
        chk("both_busy_no_pulse", np, 0);
        bullet_active_i = 0;
        wait_spawn(4, fi, kd, xv);
        chk("unstall_prompt", int'(fi >= 0 && fi <= 1), 1);
        chk("unstall_kind_bullet", kd, 2);
        bomb_active_i = 0;

        // Bomb inventory
        for (int i = 0; i < 4; i++) begin
            bomb_op(1, 0, cnt, clr);
            chk("take_count", cnt, exp_take[i]);
        end
        for (int i = 0; i < 3; i++) begin
            bomb_op(0, 1, cnt, clr);
            chk("use_count", cnt, 2 - i);
            chk("use_clear", clr, 1);
        end
        bomb_op(0, 1, cnt, clr);
        chk("empty_use_count", cnt, 0);
        chk("empty_use_clear", clr, 0);
        bomb_op(1, 1, cnt, clr);
        chk("both_at0_count", cnt, 1);
        chk("both_at0_clear", clr, 0);
        bomb_op(1, 0, cnt, clr);
        bomb_op(1, 0, cnt, clr);
        bomb_op(1, 1, cnt, clr);
        chk("both_at3_count", cnt, 3);
        chk("both_at3_clear", clr, 1);

        // Double-shoot timeout
        run_double(0, 0, hi);
        chk("double_single", hi, 10);
        repeat (2) @(posedge clk_run);
        #1;
        run_double(5, 0, hi);
        chk("double_reload", hi, 15);
        repeat (2) @(posedge clk_run);
        #1;
        run_double(0, 4, hi);
        chk("double_pause", hi, 13);

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk_run); #1;
            en_i           = ($urandom_range(0, 19) != 0);
            rand_i         = 10'($urandom);
            if ($urandom_range(0, 15) == 0) bomb_active_i = ~bomb_active_i;
            if ($urandom_range(0, 15) == 0) bullet_active_i = ~bullet_active_i;
            bomb_taken_i   = ($urandom_range(0, 19) == 0);
            bomb_use_i     = ($urandom_range(0, 14) == 0);
            bullet_taken_i = ($urandom_range(0, 59) == 0);
        end

        // Reset while stalled in PICK with the double timer at 7
        @(posedge clk_run); #1;
        en_i = 1; rand_i = 10'd0; bomb_active_i = 1; bullet_active_i = 1;
        bomb_taken_i = 0; bomb_use_i = 0; bullet_taken_i = 0;
        repeat (30) @(posedge clk_run);
        #1;
        bomb_op(1, 0, cnt, clr);
        bullet_taken_i = 1;
        @(posedge clk_run); #1;
        bullet_taken_i = 0;
        repeat (3) @(posedge clk_run);
        #1;
        chk("pre_reset_mode", int'(shoot_mode_o), 1);
        chk("pre_reset_bombs_nonzero", int'(bomb_cnt_o != 2'd0), 1);
        #2 rst = 1;
        #1;
        chk("async_rst_spawn_bomb", int'(spawn_bomb_o), 0);
        chk("async_rst_spawn_bullet", int'(spawn_bullet_o), 0);
        chk("async_rst_bomb_cnt", int'(bomb_cnt_o), 0);
        chk("async_rst_clear", int'(clear_screen_o), 0);
        chk("async_rst_mode", int'(shoot_mode_o), 0);
        @(posedge clk_run); #2;
        bomb_active_i = 0; bullet_active_i = 0; rand_i = 10'd0; en_i = 1;
        rst = 0;
        measure_spawn(13, fi, np, kd, xv, sn);
        chk("post_reset_latency", fi, 6);
        chk("post_reset_count", np, 1);

        @(posedge clk_run); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
